// File: rtl/simon_dec_datapath_2ti_pkg.sv
// Shared constants, state encoding and rotate helper for the two-share
// SIMON-128/128 decryption datapath.
package simon_dec_datapath_2ti_pkg;

  localparam int unsigned WORD     = 64;
  localparam int unsigned ROUNDS   = 68;
  localparam int unsigned LOAD_CYC = 2 * WORD;
  localparam int unsigned RND_CYC  = 2 * ROUNDS;

  // SIMON round-function rotation amounts
  localparam int unsigned ROT_A = 1;
  localparam int unsigned ROT_B = 8;
  localparam int unsigned ROT_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Left rotate by n (0 < n < WORD)
  function automatic logic [WORD-1:0] rotl(input logic [WORD-1:0] v, input int unsigned n);
    return (v << n) | (v >> (WORD - n));
  endfunction

endpackage

// File: rtl/simon_dec_datapath_2ti_if.sv
// Handshake / data bus of the masked SIMON decryption datapath.
interface simon_dec_datapath_2ti_if;
  import simon_dec_datapath_2ti_pkg::*;

  logic                start;
  logic                data_ina;
  logic                data_inb;
  logic [WORD-1:0]     key_ina;
  logic [WORD-1:0]     key_inb;
  logic [6:0]          round_idx;
  logic                busy;
  logic                plain_valid;
  logic [2*WORD-1:0]   plain_out;
  logic                out_ack;

  modport slave (
    input  start, data_ina, data_inb, key_ina, key_inb, out_ack,
    output round_idx, busy, plain_valid, plain_out
  );

  modport master (
    output start, data_ina, data_inb, key_ina, key_inb, out_ack,
    input  round_idx, busy, plain_valid, plain_out
  );

endinterface

// File: rtl/simon_dec_datapath_2ti_share.sv
// One share of the masked inverse round: X/Y registers, bit-serial load
// and the two-phase round update (own terms, then cross term + key).
module simon_dec_share
  import simon_dec_datapath_2ti_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en_i,
  input  logic            rnd_en_i,
  input  logic            phase_i,
  input  logic            din_i,
  input  logic [WORD-1:0] key_i,
  input  logic [WORD-1:0] X_in,
  output logic [WORD-1:0] X_out,
  output logic [WORD-1:0] y_o
);

  logic [WORD-1:0] x_q, x_d;
  logic [WORD-1:0] y_q, y_d;

  // Next-state: {X,Y} shift on load; phase0 own terms, phase1 cross term and key
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_en_i) begin
      x_d = {din_i, x_q[WORD-1:1]};
      y_d = {x_q[0], y_q[WORD-1:1]};
    end else if (rnd_en_i) begin
      if (!phase_i) begin
        y_d = x_q ^ rotl(y_q, ROT_C) ^ (rotl(y_q, ROT_B) & rotl(y_q, ROT_A));
        x_d = y_q;
      end else begin
        // x_q now holds the previous Y of this share; pair it with the other share's
        y_d = y_q ^ key_i ^ (rotl(x_q, ROT_A) & rotl(X_in, ROT_B));
      end
    end
  end

  // Share state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign X_out = x_q;
  assign y_o   = y_q;

endmodule

// File: rtl/simon_dec_datapath_2ti.sv
// Two-share SIMON-128/128 decryption datapath: sequencing FSM, cycle counter,
// two cross-coupled share slices and the gated unmasking XOR.
module simon_dec_datapath_2ti
  import simon_dec_datapath_2ti_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  simon_dec_datapath_2ti_if.slave  bus
);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            load_en, rnd_en, phase;
  logic [WORD-1:0] xa, xb, ya, yb;

  assign load_en = (state_q == ST_LOAD);
  assign rnd_en  = (state_q == ST_ROUND);
  assign phase   = cnt_q[0];

  // FSM next state and cycle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(LOAD_CYC - 1)) begin
          state_d = ST_ROUND;
          cnt_d   = '0;
        end
      end
      ST_ROUND: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(RND_CYC - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        if (bus.out_ack) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  simon_dec_share u_share_a (
    .clk       (clk),
    .rst       (rst),
    .load_en_i (load_en),
    .rnd_en_i  (rnd_en),
    .phase_i   (phase),
    .din_i     (bus.data_ina),
    .key_i     (bus.key_ina),
    .X_in      (xb),
    .X_out     (xa),
    .y_o       (ya)
  );

  simon_dec_share u_share_b (
    .clk       (clk),
    .rst       (rst),
    .load_en_i (load_en),
    .rnd_en_i  (rnd_en),
    .phase_i   (phase),
    .din_i     (bus.data_inb),
    .key_i     (bus.key_inb),
    .X_in      (xa),
    .X_out     (xb),
    .y_o       (yb)
  );

  // Status outputs; shares are only combined while DONE
  always_comb begin
    bus.busy        = load_en | rnd_en;
    bus.plain_valid = (state_q == ST_DONE);
    bus.round_idx   = rnd_en ? (7'(ROUNDS - 1) - cnt_q[7:1]) : '0;
    bus.plain_out   = (state_q == ST_DONE) ? {xa ^ xb, ya ^ yb} : '0;
  end

endmodule
